ring_osc_freq_meter: RTL and testbench
======================================

// Module: ring_osc_freq_meter
// PURPOSE
//   Measures the ring oscillator from the system clock domain. It counts rising edges of the free-running
//   oscillator output (normally clk_out_div) over a gate window of N system clocks and reports the count.
//   Sits between the ring oscillator and the game's status/debug readout. Used for on-silicon
//   characterisation and as an entropy/seed source.
// PARAMETERS
//   COUNT_BITS   16  width of the edge counter and of the result.
//   GATE_BITS    16  width of the gate-length input and of the gate timer.
//   SYNC_STAGES   2  flip-flop stages in the osc_in synchroniser. Must be >= 2.
// PORTS
//   clk        in   1           system clock. Single clock domain.
//   rst        in   1           synchronous, active-high reset.
//   osc_in     in   1           asynchronous oscillator signal. Must be < clk/2 in frequency.
//   start      in   1           request a measurement. Sampled only in IDLE.
//   gate_len   in   GATE_BITS   gate window length in clk cycles. Latched when start is accepted.
//   busy       out  1           high in SETTLE and GATE.
//   done       out  1           one-cycle pulse when the result is updated.
//   count      out  COUNT_BITS  rising edges seen in the last gate window. Held until the next done.
//   overflow   out  1           the last window saturated the counter. Held with count.
// BEHAVIOUR
//   Reset
//     - All state is reset: synchroniser flops and edge-detect flop cleared to 0, FSM returns to IDLE.
//     - busy=0, done=0, count=0, overflow=0.
//     - Reset mid-measurement aborts the window: no done pulse, result cleared.
//   Synchroniser and edge detect
//     - osc_in passes through SYNC_STAGES flops, then one edge-detect flop.
//     - rise = sync_out & ~prev. At most one edge per clk.
//   FSM states: IDLE, SETTLE, GATE, DONE.
//     - IDLE: if start, latch gate_len, clear the working counter, go to SETTLE. Otherwise stay.
//     - SETTLE: lasts exactly SYNC_STAGES cycles. Edges are discarded to flush stale synchroniser
//       contents. Then go to GATE, or straight to DONE if the latched gate_len == 0.
//     - GATE: lasts exactly gate_len cycles. Each cycle with rise=1 increments the working counter.
//       - Saturation: at all-ones the counter holds and a sticky flag is set.
//       - After the last GATE cycle, go to DONE.
//     - DONE: one cycle. count <= working counter, overflow <= sticky flag, done=1. Then go to IDLE.
//   Timing
//     - start sampled in IDLE at cycle T gives done at T + 1 + SYNC_STAGES + gate_len.
//     - count and overflow are valid in the same cycle as done.
//     - The next start is accepted at T + 2 + SYNC_STAGES + gate_len at the earliest.
//   Boundary conditions
//     - start outside IDLE (including in DONE) is ignored. gate_len changes after latching are ignored.
//     - An edge in the final GATE cycle is counted. An edge in the DONE cycle is not.
//     - Expected count is f_osc * gate_len / f_clk, +/-1 due to synchroniser phase.
//     - osc_in stuck at either level gives count=0.
//     - The gate timer counts down from the latched value with no wrap. GATE_BITS all-ones is a legal gate.
// STRUCTURE
//   - Shared header ring_osc_pkg.vh: FSM state encodings (IDLE=0, SETTLE=1, GATE=2, DONE=3) and the
//     default COUNT_BITS, GATE_BITS and SYNC_STAGES constants.
//   - Sub-module osc_edge_sync (param SYNC_STAGES; ports clk, rst, async_in, rise): synchroniser plus
//     rising-edge detector. Reused by other async-input consumers.
//   - Top level: FSM, gate down-counter, saturating edge counter, result and overflow registers.
// TESTING
//   1. osc_in period 10 clk, gate_len=100, start at T -> done at T+103, count in {9,10,11}, overflow=0.
//   2. gate_len=0, start at T -> done at T+3, count=0, overflow=0, busy high for cycles T+1..T+2.
//   3. COUNT_BITS=4, osc period 4 clk, gate_len=100 -> count=15, overflow=1. The next run with
//      gate_len=8 -> overflow=0, count in {1,2,3}.
//   4. start pulsed again mid-GATE with a different gate_len -> ignored. A single done arrives at the
//      original latency with the original window.
//   5. rst asserted for 1 cycle mid-GATE -> next cycle busy=0, count=0, overflow=0, and no done
//      until a new start.
//   6. osc_in held at 1, then at 0, gate_len=50 -> count=0 for both runs.

Source files
------------

// File: rtl/ring_osc_freq_meter_pkg.sv
// Shared constants, FSM encoding and a sizing helper for the ring oscillator frequency meter.
package ring_osc_freq_meter_pkg;

    localparam int unsigned COUNT_BITS_DEF  = 16;
    localparam int unsigned GATE_BITS_DEF   = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StGate   = 2'd2,
        StDone   = 2'd3
    } meter_state_e;

    // Bits needed for a down-counter that runs from stages-1 to 0.
    function automatic int unsigned settle_width(input int unsigned stages);
        return (stages <= 2) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module osc_edge_sync
    import ring_osc_freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("osc_edge_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the async input through the synchroniser; remember the last synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge-detect registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts synchronised rising edges of osc_in over a gate window of gate_len system clocks.
module ring_osc_freq_meter
    import ring_osc_freq_meter_pkg::*;
#(
    parameter int unsigned COUNT_BITS  = COUNT_BITS_DEF,
    parameter int unsigned GATE_BITS   = GATE_BITS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    input  logic                  start,
    input  logic [GATE_BITS-1:0]  gate_len,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_BITS-1:0] count,
    output logic                  overflow
);

    localparam int unsigned SW = settle_width(SYNC_STAGES);

    logic                  rise;
    meter_state_e          state_q, state_d;
    logic [GATE_BITS-1:0]  gate_q, gate_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [COUNT_BITS-1:0] cnt_q, cnt_d, cnt_inc;
    logic                  sat_q, sat_d, sat_inc;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    osc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (osc_in),
        .rise     (rise)
    );

    // Saturating edge counter value including this cycle's edge.
    always_comb begin
        cnt_inc = cnt_q;
        sat_inc = sat_q;
        if (rise) begin
            if (&cnt_q) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + COUNT_BITS'(1);
            end
        end
    end

    // FSM next state, gate/settle timers and result capture on entry to DONE.
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d   = gate_len;
                    cnt_d    = '0;
                    sat_d    = 1'b0;
                    settle_d = SW'(SYNC_STAGES - 1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                // Edges here come from stale synchroniser contents and are dropped.
                if (settle_q == '0) begin
                    if (gate_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        count_d = cnt_q;
                        ovf_d   = sat_q;
                    end else begin
                        state_d = StGate;
                    end
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            StGate: begin
                cnt_d  = cnt_inc;
                sat_d  = sat_inc;
                gate_d = gate_q - GATE_BITS'(1);
                if (gate_q == GATE_BITS'(1)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    count_d = cnt_inc;
                    ovf_d   = sat_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StSettle) || (state_d == StGate);
    end

    // State, timers, working counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            gate_q   <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Randomised bench for ring_osc_freq_meter with a per-cycle behavioural reference model.
module tb_ring_osc_freq_meter;

    localparam int CB   = 4;
    localparam int GB   = 8;
    localparam int SS   = 2;
    localparam int MAXC = 20000;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          osc_in   = 1'b0;
    logic          start    = 1'b0;
    logic [GB-1:0] gate_len = '0;
    logic          busy, done, overflow;
    logic [CB-1:0] count;

    ring_osc_freq_meter #(
        .COUNT_BITS  (CB),
        .GATE_BITS   (GB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .osc_in   (osc_in),
        .start    (start),
        .gate_len (gate_len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oscillator: mode 0 stuck low, 1 stuck high, 2 square wave with osc_hi/osc_lo clk phases.
    int osc_mode = 0;
    int osc_hi   = 5;
    int osc_lo   = 5;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            #2;
            if (osc_mode == 2) begin
                ph++;
                if (osc_in && ph >= osc_hi) begin
                    osc_in = 1'b0;
                    ph = 0;
                end else if (!osc_in && ph >= osc_lo) begin
                    osc_in = 1'b1;
                    ph = 0;
                end
            end else begin
                osc_in = (osc_mode == 1);
                ph = 0;
            end
        end
    end

    // Reference model. hist[p] is osc_in as sampled at posedge p. A measurement accepted at
    // posedge p finishes at posedge p+SS+G and counts 0->1 transitions between samples p..p+G.
    bit hist [MAXC];
    int cyc      = 0;
    bit m_active = 1'b0;
    int m_p      = 0;
    int m_g      = 0;
    bit m_done   = 1'b0;
    bit m_busy   = 1'b0;
    int m_count  = 0;
    bit m_ovf    = 1'b0;
    initial begin
        bit accept;
        int edges;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d, want %0d", cyc, MAXC - 1);
                $fatal(1, "cycle budget exhausted");
            end
            if (rst) begin
                for (int i = 0; i <= SS; i++) if (cyc - i >= 0) hist[cyc - i] = 1'b0;
                m_active = 1'b0;
                m_done   = 1'b0;
                m_busy   = 1'b0;
                m_count  = 0;
                m_ovf    = 1'b0;
            end else begin
                hist[cyc] = osc_in;
                accept = !m_active && !m_done;
                m_done = 1'b0;
                if (m_active && cyc == m_p + SS + m_g) begin
                    edges = 0;
                    for (int m = m_p + 1; m <= m_p + m_g; m++)
                        if (hist[m] && !hist[m - 1]) edges++;
                    m_count  = (edges > CMAX) ? CMAX : edges;
                    m_ovf    = (edges > CMAX);
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
                if (accept && start) begin
                    m_active = 1'b1;
                    m_p      = cyc;
                    m_g      = int'(gate_len);
                end
                m_busy = m_active && (cyc < m_p + SS + m_g);
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("busy", busy === m_busy, busy, m_busy);
                check("done", done === m_done, done, m_done);
                check("count", count === CB'(m_count), count, m_count);
                check("overflow", overflow === m_ovf, overflow, m_ovf);
                if (done === 1'b1) n_done++;
            end
        end
    end

    // One measurement; optional second start re_at cycles after the first.
    task automatic run(input int g, input int re_at, input int g2,
                       output int lat, output int cnt, output int ovf);
        int t0;
        bit seen;
        seen = 1'b0;
        lat = -1;
        cnt = -1;
        ovf = -1;
        @(negedge clk);
        start    = 1'b1;
        gate_len = GB'(g);
        t0       = cyc;
        @(negedge clk);
        start    = 1'b0;
        gate_len = GB'($urandom);
        for (int i = 1; i <= g + SS + 20 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - t0;
                cnt  = int'(count);
                ovf  = int'(overflow);
            end else begin
                if (i == re_at) begin
                    start    = 1'b1;
                    gate_len = GB'(g2);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", seen, seen, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat, cnt, ovf, nd0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy === 1'b0, busy, 0);
        check("reset_count", count === '0, count, 0);
        check("reset_overflow", overflow === 1'b0, overflow, 0);
        rst = 1'b0;

        // Period 10 clocks over 100 cycles.
        osc_mode = 2; osc_hi = 5; osc_lo = 5;
        idle(7);
        run(100, -1, 0, lat, cnt, ovf);
        check("t1_latency", lat == 103, lat, 103);
        check("t1_count", cnt >= 9 && cnt <= 11, cnt, 10);
        check("t1_overflow", ovf == 0, ovf, 0);

        // Empty gate: SETTLE only, then DONE.
        idle(2);
        nd0 = cyc;
        run(0, -1, 0, lat, cnt, ovf);
        check("t2_latency", lat == 3, lat, 3);
        check("t2_count", cnt == 0, cnt, 0);
        check("t2_overflow", ovf == 0, ovf, 0);

        // Saturation, then a short clean run.
        osc_mode = 2; osc_hi = 2; osc_lo = 2;
        idle(5);
        run(100, -1, 0, lat, cnt, ovf);
        check("t3_sat_count", cnt == 15, cnt, 15);
        check("t3_sat_overflow", ovf == 1, ovf, 1);
        run(8, -1, 0, lat, cnt, ovf);
        check("t3_short_count", cnt >= 1 && cnt <= 3, cnt, 2);
        check("t3_short_overflow", ovf == 0, ovf, 0);

        // Second start mid-GATE must be ignored.
        osc_mode = 2; osc_hi = 3; osc_lo = 3;
        idle(4);
        nd0 = n_done;
        run(30, 10, 5, lat, cnt, ovf);
        check("t4_latency", lat == 33, lat, 33);
        check("t4_count", cnt >= 4 && cnt <= 6, cnt, 5);
        idle(12);
        check("t4_single_done", n_done - nd0 == 1, n_done - nd0, 1);

        // Reset mid-GATE aborts the window.
        @(negedge clk);
        start = 1'b1; gate_len = GB'(60);
        @(negedge clk);
        start = 1'b0;
        idle(20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy === 1'b0, busy, 0);
        check("t5_count", count === '0, count, 0);
        check("t5_overflow", overflow === 1'b0, overflow, 0);
        nd0 = n_done;
        idle(80);
        check("t5_no_done", n_done == nd0, n_done - nd0, 0);

        // Stuck oscillator at either level.
        osc_mode = 1;
        idle(6);
        run(50, -1, 0, lat, cnt, ovf);
        check("t6_high_count", cnt == 0, cnt, 0);
        osc_mode = 0;
        idle(6);
        run(50, -1, 0, lat, cnt, ovf);
        check("t6_low_count", cnt == 0, cnt, 0);

        // All-ones gate length.
        osc_mode = 2; osc_hi = 5; osc_lo = 5;
        idle(4);
        run(255, -1, 0, lat, cnt, ovf);
        check("max_gate_latency", lat == 258, lat, 258);
        check("max_gate_overflow", ovf == 1, ovf, 1);

        // Random traffic: starts at any time, gate changes, occasional resets, varying osc.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 200 == 0) begin
                osc_mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : 2;
                osc_hi   = $urandom_range(1, 6);
                osc_lo   = $urandom_range(2, 6);
            end
            start    = ($urandom_range(0, 7) == 0);
            gate_len = GB'($urandom_range(0, 40));
            rst      = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        idle(60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
